// File: rtl/mips_pkg.sv
// Shared MIPS datapath constants used by the register file and the ALU.
package mips_pkg;

    localparam int DATA_W = 32;
    localparam int REG_AW = 5;
    localparam logic [REG_AW-1:0] ZERO_REG = 5'd0;

endpackage

// File: rtl/grf_rdport.sv
// One combinational read port: zero-register masking plus optional write-first
// forwarding when GRF_BYPASS_EN is defined.
module grf_rdport
    import mips_pkg::*;
#(
    parameter int DATA_W = mips_pkg::DATA_W
) (
    input  logic [REG_AW-1:0] ra,
    input  logic [DATA_W-1:0] reg_data,
    input  logic              reset,
    input  logic              we,
    input  logic [REG_AW-1:0] wa,
    input  logic [DATA_W-1:0] wd,
    output logic [DATA_W-1:0] rd
);

`ifdef GRF_BYPASS_EN
    logic fwd_s;
    // A write that will commit this edge to the same address is forwarded.
    assign fwd_s = we && !reset && (wa != ZERO_REG) && (wa == ra);
`else
    logic unused_s;
    assign unused_s = ^{reset, we, wa, wd};
`endif

    // Select masked, forwarded or stored data for this port.
    always_comb begin
        rd = {DATA_W{1'b0}};
        if (ra == ZERO_REG) begin
            rd = {DATA_W{1'b0}};
`ifdef GRF_BYPASS_EN
        end else if (fwd_s) begin
            rd = wd;
`endif
        end else begin
            rd = reg_data;
        end
    end

endmodule

// File: rtl/grf.sv
// General register file: two combinational read ports, one write port, and a
// committed-write counter. Optional forwarding is enabled by GRF_BYPASS_EN.
module grf
    import mips_pkg::*;
#(
    parameter int DATA_W = mips_pkg::DATA_W,
    parameter int NREG   = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              we,
    input  logic [REG_AW-1:0] wa,
    input  logic [DATA_W-1:0] wd,
    input  logic [REG_AW-1:0] ra1,
    input  logic [REG_AW-1:0] ra2,
    output logic [DATA_W-1:0] rd1,
    output logic [DATA_W-1:0] rd2,
    output logic [31:0]       wcnt
);

    logic [DATA_W-1:0] regs_r [NREG];
    logic [31:0]       wcnt_r;
    logic              commit_s;

    // Writes to register 0 are dropped and do not count as committed.
    assign commit_s = we && (wa != ZERO_REG);

    // Register storage and write counter.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < NREG; i++) begin
                regs_r[i] <= {DATA_W{1'b0}};
            end
            wcnt_r <= 32'd0;
        end else if (commit_s) begin
            regs_r[wa] <= wd;
            wcnt_r     <= wcnt_r + 32'd1;
        end
    end

    assign wcnt = wcnt_r;

    grf_rdport #(.DATA_W(DATA_W)) u_rdport1 (
        .ra       (ra1),
        .reg_data (regs_r[ra1]),
        .reset    (reset),
        .we       (we),
        .wa       (wa),
        .wd       (wd),
        .rd       (rd1)
    );

    grf_rdport #(.DATA_W(DATA_W)) u_rdport2 (
        .ra       (ra2),
        .reg_data (regs_r[ra2]),
        .reset    (reset),
        .we       (we),
        .wa       (wa),
        .wd       (wd),
        .rd       (rd2)
    );

endmodule

// File: doc/grf.md
GRF -- requirements
Module: grf

Interface
- REQ-001: Parameter DATA_W, default 32, register and data width; SHALL match ALU operand width.
- REQ-002: Parameter NREG, default 32, number of registers; address width SHALL be 5 bits (log2 NREG).
- REQ-003: clk  input  1  single system clock; all state SHALL update on the rising edge only.
- REQ-004: reset  input  1  synchronous, active-high reset, sampled on the rising edge of clk.
- REQ-005: we  input  1  write enable for the write port.
- REQ-006: wa  input  5  write address.
- REQ-007: wd  input  DATA_W  write data (ALU result or memory load data).
- REQ-008: ra1  input  5  read address, port 1 (drives ALU operand a).
- REQ-009: ra2  input  5  read address, port 2 (drives ALU operand b).
- REQ-010: rd1  output  DATA_W  read data, port 1.
- REQ-011: rd2  output  DATA_W  read data, port 2.
- REQ-012: wcnt  output  32  count of committed writes, for the debug and trace hook.

Function
- REQ-013: Storage SHALL be NREG registers of DATA_W bits.
- REQ-014: A write SHALL commit at the rising clk edge when reset=0, we=1 and wa!=0; it is visible from the following cycle.
- REQ-015: A write with wa=0 SHALL be discarded; register 0 SHALL always read 0, and wcnt SHALL NOT increment.
- REQ-016: Reads SHALL be combinational, with zero cycles of latency from ra1/ra2 to rd1/rd2.
- REQ-017: When ra1=0 (or ra2=0), rd1 (or rd2) SHALL be 0 regardless of any write.
- REQ-018: When ra1=ra2, rd1 and rd2 SHALL be identical.
- REQ-019: wcnt SHALL increment by 1 on each committed write and wrap from 0xFFFFFFFF to 0.
- REQ-020: Read-during-write to the same nonzero address is governed by REQ-025 and REQ-026.
- REQ-021: When we=0, wa and wd SHALL be don't-care, and no state changes except through reset.

Reset
- REQ-022: When reset=1 at a rising edge, all registers SHALL become 0 and wcnt SHALL become 0. A coincident we=1 SHALL be ignored.
- REQ-023: Reset asserted mid-sequence SHALL discard the pending write of that cycle; rd1/rd2 SHALL read 0 from the next cycle.
- REQ-024: While reset is held high, rd1 and rd2 SHALL read 0 for all addresses from the cycle after the first reset edge.

Configuration
- REQ-025: With macro GRF_BYPASS_EN defined: when we=1, wa!=0, reset=0 and ra1==wa (or ra2==wa), rd1 (or rd2) SHALL equal wd in the same cycle (write-first forwarding).
- REQ-026: With GRF_BYPASS_EN undefined: under the same conditions, rd1/rd2 SHALL return the old register value until the edge commits (read-first).

Structure
- REQ-027: DATA_W, the 5-bit register-address width and the constant ZERO_REG=0 SHALL live in the shared package mips_pkg, which the ALU also uses.
- REQ-028: One sub-module, grf_rdport, SHALL be instantiated twice. It is purely combinational and implements the zero-register masking and the optional bypass mux for one read port.
- REQ-029: The storage array and wcnt SHALL reside in grf only; grf_rdport SHALL hold no state.

Verification
- REQ-030: Apply reset for 1 cycle, then read ra1=5, ra2=31 -> rd1=0, rd2=0, wcnt=0.
- REQ-031: Write wa=3, wd=0x00000001, we=1 for one cycle, then ra1=3, ra2=3 -> rd1=rd2=0x00000001, wcnt=1. Feeding these to the ALU with op=2'b01 SHALL produce the ALU's defined op-01 result.
- REQ-032: Write wa=0, wd=0xDEADBEEF -> ra1=0 reads 0 and wcnt is unchanged.
- REQ-033: Same cycle: we=1, wa=7, wd=0x12345678, ra1=7, where reg7 already holds 0xAAAA0000 -> rd1=0x12345678 with GRF_BYPASS_EN, or 0xAAAA0000 without it. The next cycle reads 0x12345678 in both builds.
- REQ-034: Write wa=9, wd=0xFFFFFFFF, then assert reset together with we=1, wa=9, wd=0x1 -> the next cycle ra1=9 reads 0 and wcnt=0.
- REQ-035: Preload wcnt to 0xFFFFFFFF through a bench force, then perform one committed write -> wcnt=0.
